// File: rtl/multi_debounce.sv
// Multi-channel push-button debouncer: 2-flop sync, stability counter, edge pulses.
// Optional long-hold detector built only when DEBOUNCE_HOLD_EN is defined.
module multi_debounce_lane #(
   parameter int CNT_WIDTH     = 16,
   parameter int STABLE_CYCLES = 50000,
   parameter int RESET_VALUE   = 1,
   parameter int ACTIVE_LEVEL  = 0,
   parameter int HOLD_WIDTH    = 25,
   parameter int HOLD_CYCLES   = 25000000
) (
   input  logic clk25,
   input  logic rst_n,
   input  logic din,
   output logic dout,
   output logic rise,
   output logic fall,
   output logic hold
);
   localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(STABLE_CYCLES - 1);
   localparam logic RST_LVL = 1'(RESET_VALUE != 0);

   if (STABLE_CYCLES < 1 || 64'(STABLE_CYCLES) > (64'd1 << CNT_WIDTH)) begin : g_bad_cnt
      $error("STABLE_CYCLES out of range for CNT_WIDTH");
   end
   if (HOLD_CYCLES < 1 || 64'(HOLD_CYCLES) > (64'd1 << HOLD_WIDTH)) begin : g_bad_hold
      $error("HOLD_CYCLES out of range for HOLD_WIDTH");
   end
   if (RESET_VALUE > 1 || ACTIVE_LEVEL > 1) begin : g_bad_lvl
      $error("RESET_VALUE and ACTIVE_LEVEL must be 0 or 1");
   end

   logic                 sync1, sync2;
   logic [CNT_WIDTH-1:0] cnt;
   logic                 flip;

   assign flip = (sync2 != dout) && (cnt == CNT_MAX);

   always_ff @(posedge clk25 or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= RST_LVL;
         sync2 <= RST_LVL;
         dout  <= RST_LVL;
         cnt   <= '0;
         rise  <= 1'b0;
         fall  <= 1'b0;
      end else begin
         sync1 <= din;
         sync2 <= sync1;
         rise  <= flip & sync2;
         fall  <= flip & ~sync2;
         // any sample matching the output restarts qualification
         if (sync2 == dout) begin
            cnt <= '0;
         end else if (flip) begin
            cnt  <= '0;
            dout <= sync2;
         end else begin
            cnt <= cnt + CNT_WIDTH'(1);
         end
      end
   end

`ifdef DEBOUNCE_HOLD_EN
   localparam logic [HOLD_WIDTH-1:0] HOLD_MAX = HOLD_WIDTH'(HOLD_CYCLES - 1);
   localparam logic ACT_LVL = 1'(ACTIVE_LEVEL != 0);

   logic [HOLD_WIDTH-1:0] hcnt;
   logic                  held;
   logic                  pressed;

   assign pressed = (dout == ACT_LVL);

   // hcnt stops one short and 'held' marks saturation, so HOLD_CYCLES may equal 2^HOLD_WIDTH
   always_ff @(posedge clk25 or negedge rst_n) begin
      if (!rst_n) begin
         hcnt <= '0;
         held <= 1'b0;
         hold <= 1'b0;
      end else if (!pressed) begin
         hcnt <= '0;
         held <= 1'b0;
         hold <= 1'b0;
      end else if (held) begin
         hold <= 1'b0;
      end else if (hcnt == HOLD_MAX) begin
         held <= 1'b1;
         hold <= ~flip;
      end else begin
         hcnt <= hcnt + HOLD_WIDTH'(1);
         hold <= 1'b0;
      end
   end
`else
   assign hold = 1'b0;
`endif
endmodule

module multi_debounce #(
   parameter int CHANNELS      = 2,
   parameter int CNT_WIDTH     = 16,
   parameter int STABLE_CYCLES = 50000,
   parameter int RESET_VALUE   = 1,
   parameter int ACTIVE_LEVEL  = 0,
   parameter int HOLD_WIDTH    = 25,
   parameter int HOLD_CYCLES   = 25000000
) (
   input  logic                clk25,
   input  logic                rst_n,
   input  logic [CHANNELS-1:0] sig_in,
   output logic [CHANNELS-1:0] sig_out,
   output logic [CHANNELS-1:0] rise,
   output logic [CHANNELS-1:0] fall,
   output logic [CHANNELS-1:0] hold
);
   multi_debounce_lane #(
      .CNT_WIDTH    (CNT_WIDTH),
      .STABLE_CYCLES(STABLE_CYCLES),
      .RESET_VALUE  (RESET_VALUE),
      .ACTIVE_LEVEL (ACTIVE_LEVEL),
      .HOLD_WIDTH   (HOLD_WIDTH),
      .HOLD_CYCLES  (HOLD_CYCLES)
   ) u_lane [CHANNELS-1:0] (
      .clk25(clk25),
      .rst_n(rst_n),
      .din  (sig_in),
      .dout (sig_out),
      .rise (rise),
      .fall (fall),
      .hold (hold)
   );
endmodule
